dmem_uart_mmio: RTL and testbench

//  Data-memory subsystem on the core's data port, directly downstream of the pipelined arm core.

---
 rtl/dmem_uart_mmio.sv | 232 +++++++++++++++++++++++
 tb/tb_dmem_uart_mmio.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_uart_mmio.sv
// dmem_uart_mmio
//   Data-memory subsystem for the core's data port. A word RAM sits at byte
//   address 0 and a memory-mapped UART transmitter sits at UART_BASE. The UART
//   has a TX FIFO feeding an 8N1 serializer, so software can queue bytes and
//   move on without polling every bit.
//
//   Ports
//     clk        core clock, all state updates on the rising edge
//     reset      synchronous, active-high reset
//     MemWrite   store strobe from the memory stage
//     ALUResult  byte address (word access only, bits [1:0] ignored by decode)
//     WriteData  store data
//     ReadData   load data, combinational from ALUResult
//     uart_tx    serial output, idle high, registered
//     tx_busy    serializer active or FIFO holding bytes
//
//   Register map
//     UART_BASE+0  TXDATA  write: queue WriteData[7:0]; read: 0
//     UART_BASE+4  STATUS  read: {28'b0, overflow, busy, empty, full};
//                          any write clears overflow
module dmem_uart_mmio #(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter int          BAUD_DIV   = 16,
  parameter logic [31:0] UART_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int          RAM_AW      = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES   = 32'(RAM_WORDS * 4);
  localparam logic [31:0] STATUS_ADDR = UART_BASE + 32'd4;
  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam int          CNT_W       = PTR_W + 1;
  localparam int          BCNT_W      = $clog2(BAUD_DIV);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

  // Address decode
  logic              ram_hit;
  logic              txdata_hit;
  logic              status_hit;
  logic [RAM_AW-1:0] ram_idx;

  assign ram_hit    = (ALUResult < RAM_BYTES);
  assign txdata_hit = (ALUResult[31:2] == UART_BASE[31:2]);
  assign status_hit = (ALUResult[31:2] == STATUS_ADDR[31:2]);
  assign ram_idx    = ALUResult[RAM_AW+1:2];

  // Word RAM: asynchronous read, so a same-cycle read of the word being
  // written sees the old contents. Not touched by reset.
  logic [31:0] mem_q [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) begin
      mem_q[ram_idx] <= WriteData;
    end
  end

  // TX FIFO
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_head;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             overflow_q;

  tx_state_t         state_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [2:0]        bit_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              baud_end;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_q[rd_ptr_q];
  assign baud_end   = (bcnt_q == BCNT_W'(BAUD_DIV - 1));

  // The serializer takes the head byte either from IDLE or on the last stop
  // cycle (back-to-back frames). A full FIFO can still accept a byte on that
  // same edge because the slot being overwritten is the one leaving.
  assign pop      = !fifo_empty &&
                    ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_end));
  assign push_req = MemWrite && txdata_hit;
  assign push_ok  = push_req && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= WriteData[7:0];
    end
  end

  // Sticky overflow: a STATUS write clears it even if a dropped push would
  // set it on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (MemWrite && status_hit) begin
      overflow_q <= 1'b0;
    end else if (push_req && !push_ok) begin
      overflow_q <= 1'b1;
    end
  end

  // 8N1 serializer. tx_q is loaded with the level of the bit that starts on
  // the following cycle, so uart_tx is a clean register output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= fifo_head;
            bcnt_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_end) begin
            bcnt_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud_end) begin
            bcnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
            end
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
        end
        S_STOP: begin
          if (baud_end) begin
            bcnt_q <= '0;
            if (pop) begin
              shift_q <= fifo_head;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            bcnt_q <= bcnt_q + BCNT_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign uart_tx = tx_q;
  assign tx_busy = (state_q != S_IDLE) || !fifo_empty;

  // Load data mux; TXDATA and unmapped addresses read as zero.
  always_comb begin
    ReadData = 32'h0;
    if (ram_hit) begin
      ReadData = mem_q[ram_idx];
    end else if (status_hit) begin
      ReadData = {28'h0, overflow_q, tx_busy, fifo_empty, fifo_full};
    end
  end

endmodule

// File: tb/tb_dmem_uart_mmio.sv
module tb_dmem_uart_mmio;

  localparam int          BD = 4;
  localparam logic [31:0] UB = 32'hFFFF_FF00;
  localparam logic [31:0] US = 32'hFFFF_FF04;

  localparam int K_RD   = 0;
  localparam int K_TX   = 1;
  localparam int K_BUSY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        uart_tx;
  logic        tx_busy;

  dmem_uart_mmio #(
    .RAM_WORDS (64),
    .FIFO_DEPTH(8),
    .BAUD_DIV  (BD),
    .UART_BASE (UB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .ALUResult(ALUResult),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .uart_tx  (uart_tx),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  chk_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  // Monitor: compares every expectation scheduled for the current cycle
  chk_t        mc;
  logic [31:0] act;
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mc = sbq.pop_front();
      case (mc.kind)
        K_RD:    act = ReadData;
        K_TX:    act = {31'b0, uart_tx};
        default: act = {31'b0, tx_busy};
      endcase
      n_tests++;
      if (mc.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: scheduled for cycle %0d, reached at cycle %0d", mc.name, mc.cyc, cyc);
      end else if (act !== mc.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", mc.name, act, mc.exp, cyc);
      end
    end
    if (done) begin
      if (sbq.size() != 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL leftover: got %0d unchecked entries, expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input string nm, input int kind, input logic [31:0] v);
    chk_t c;
    c.cyc  = cyc;
    c.name = nm;
    c.kind = kind;
    c.exp  = v;
    sbq.push_back(c);
  endtask

  task automatic exp_rd(input string nm, input logic [31:0] a, input logic [31:0] v);
    ALUResult = a;
    expect_sig(nm, K_RD, v);
  endtask

  task automatic expect_idle_line(input string nm);
    expect_sig({nm, "_tx"}, K_TX, 32'd1);
    expect_sig({nm, "_busy"}, K_BUSY, 32'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ALUResult = a;
    WriteData = d;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  // Checks one 10*BD cycle frame; first_now means the start bit is already
  // on the line in the current cycle.
  task automatic frame(input logic [7:0] b, input bit first_now);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10 * BD; i++) begin
      if (!(i == 0 && first_now)) tick();
      expect_sig($sformatf("frame_%02h_tx_c%0d", b, i), K_TX, {31'b0, f[i / BD]});
      expect_sig($sformatf("frame_%02h_busy_c%0d", b, i), K_BUSY, 32'd1);
    end
  endtask

  int c0;

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = 32'h0;
    WriteData = 32'h0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    exp_rd("rst_status", US, 32'h2);
    expect_idle_line("rst");
    tick();
    exp_rd("txdata_reads_zero", UB, 32'h0);
    tick();

    // RAM store/load, ignored low address bits, unmapped space
    wr(32'h10, 32'hDEADBEEF);
    exp_rd("ram_10", 32'h10, 32'hDEADBEEF);
    tick();
    exp_rd("ram_13", 32'h13, 32'hDEADBEEF);
    tick();
    exp_rd("unmapped_1000", 32'h1000, 32'h0);
    tick();

    // Read of the word being written returns the old value
    ALUResult = 32'h10;
    WriteData = 32'h12345678;
    MemWrite  = 1'b1;
    expect_sig("rdw_old", K_RD, 32'hDEADBEEF);
    tick();
    MemWrite = 1'b0;
    exp_rd("rdw_new", 32'h10, 32'h12345678);
    tick();

    wr(32'h2000, 32'hCAFEF00D);
    exp_rd("unmapped_write_ignored", 32'h2000, 32'h0);
    tick();
    wr(32'hFC, 32'h0BADF00D);
    exp_rd("ram_last_word", 32'hFC, 32'h0BADF00D);
    tick();
    exp_rd("ram_past_end", 32'h100, 32'h0);
    tick();

    // Single frame of 0x55 (upper WriteData bits ignored)
    wr(UB, 32'h0000_0155);
    expect_sig("pre_pop_tx", K_TX, 32'd1);
    expect_sig("pre_pop_busy", K_BUSY, 32'd1);
    exp_rd("pre_pop_status", US, 32'h4);
    frame(8'h55, 1'b0);
    tick();
    expect_idle_line("after_55");
    exp_rd("after_55_status", US, 32'h2);
    tick();

    // Back-to-back frames with no idle gap
    wr(UB, 32'h41);
    wr(UB, 32'h42);
    frame(8'h41, 1'b1);
    frame(8'h42, 1'b0);
    tick();
    expect_idle_line("after_4142");

    // Fill FIFO while a frame is in flight, overflow and clear
    wr(UB, 32'h10);
    c0 = cyc;
    tick();
    for (int i = 1; i <= 8; i++) wr(UB, 32'h10 + i);
    exp_rd("full_status", US, 32'h5);
    tick();
    wr(UB, 32'h19);
    exp_rd("overflow_status", US, 32'hD);
    tick();
    wr(US, 32'h0);
    exp_rd("overflow_cleared", US, 32'h5);
    tick();

    // Push on the pop edge while full: accepted, no overflow
    while (cyc < c0 + 40) tick();
    wr(UB, 32'h99);
    exp_rd("push_on_pop_status", US, 32'h5);
    frame(8'h11, 1'b1);

    // Reset during DATA bit 3 of the next frame (0x12)
    tick();
    expect_sig("f12_start", K_TX, 32'd0);
    repeat (17) tick();
    expect_sig("f12_bit3", K_TX, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_rd("post_reset_status", US, 32'h2);
    expect_idle_line("post_reset");
    for (int i = 0; i < 50; i++) begin
      tick();
      expect_idle_line($sformatf("no_frames_c%0d", i));
    end
    exp_rd("ram_survives_reset", 32'h10, 32'h12345678);
    tick();
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
